// File: rtl/inst_queue_pkg.sv
// Shared types and sizing for the instruction queue between fetcher and dispatcher.
// One queue entry carries the instruction word, its PC and the predicted-taken bit.
package inst_queue_pkg;

  localparam int QUEUE_DEPTH = 16;
  localparam int PTR_W       = $clog2(QUEUE_DEPTH);
  localparam int INST_W      = 32;
  localparam int ADDR_W      = 32;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              pred;
  } iq_entry_t;

  localparam int ENTRY_W = $bits(iq_entry_t);

  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W+1)'(QUEUE_DEPTH);
  localparam logic [PTR_W:0] THRESH_CNT = (PTR_W+1)'(QUEUE_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetcher-side, dispatcher-side and ROB/RS readiness signals of the instruction queue.
// master drives the fetch/readiness inputs; slave is the queue itself.
interface inst_queue_if;
  import inst_queue_pkg::*;

  logic              fetcher_instqueue_en_in;
  logic [INST_W-1:0] fetcher_instqueue_inst_in;
  logic [ADDR_W-1:0] fetcher_instqueue_pc_in;
  logic              fetcher_instqueue_pred_in;
  logic              instqueue_fetcher_full_out;
  logic              rs_instqueue_rdy_in;
  logic              rob_instqueue_rdy_in;
  logic              rob_instqueue_rst_in;
  logic              instqueue_dispatcher_en_out;
  logic [INST_W-1:0] instqueue_dispatcher_inst_out;
  logic [ADDR_W-1:0] instqueue_dispatcher_pc_out;
  logic              instqueue_dispatcher_pred_out;

  modport master (
    output fetcher_instqueue_en_in, fetcher_instqueue_inst_in,
           fetcher_instqueue_pc_in, fetcher_instqueue_pred_in,
           rs_instqueue_rdy_in, rob_instqueue_rdy_in, rob_instqueue_rst_in,
    input  instqueue_fetcher_full_out, instqueue_dispatcher_en_out,
           instqueue_dispatcher_inst_out, instqueue_dispatcher_pc_out,
           instqueue_dispatcher_pred_out
  );

  modport slave (
    input  fetcher_instqueue_en_in, fetcher_instqueue_inst_in,
           fetcher_instqueue_pc_in, fetcher_instqueue_pred_in,
           rs_instqueue_rdy_in, rob_instqueue_rdy_in, rob_instqueue_rst_in,
    output instqueue_fetcher_full_out, instqueue_dispatcher_en_out,
           instqueue_dispatcher_inst_out, instqueue_dispatcher_pc_out,
           instqueue_dispatcher_pred_out
  );

endinterface

// File: rtl/inst_queue_ram.sv
// QUEUE_DEPTH-entry storage: one synchronous write port, one asynchronous read port.
// No reset; contents are only meaningful between the queue's head and tail.
module inst_queue_ram
  import inst_queue_pkg::*;
(
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  iq_entry_t        wr_dat_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output iq_entry_t        rd_dat_o
);

  iq_entry_t mem_q [QUEUE_DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/inst_queue.sv
// Circular instruction FIFO, fetcher -> dispatcher; issue is registered, one entry per cycle
// when RS and ROB are ready (next edge after push, same edge with INSTQUEUE_BYPASS_EN).
module inst_queue
  import inst_queue_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  inst_queue_if.slave iq
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             en_q, en_d;
  iq_entry_t        out_q, out_d;

  logic      pop, push, bypass, wr_en;
  iq_entry_t wr_dat, rd_dat;

  assign wr_dat = '{inst: iq.fetcher_instqueue_inst_in,
                    pc:   iq.fetcher_instqueue_pc_in,
                    pred: iq.fetcher_instqueue_pred_in};

  inst_queue_ram u_ram (
    .clk_i     (clk_in),
    .wr_en_i   (wr_en),
    .wr_addr_i (tail_q),
    .wr_dat_i  (wr_dat),
    .rd_addr_i (head_q),
    .rd_dat_o  (rd_dat)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    en_d    = 1'b0;
    out_d   = out_q;
    pop     = 1'b0;
    push    = 1'b0;
    bypass  = 1'b0;
    wr_en   = 1'b0;

    if (rdy_in && iq.rob_instqueue_rst_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy_in) begin
      pop  = (count_q != '0) && iq.rs_instqueue_rdy_in && iq.rob_instqueue_rdy_in;
      push = iq.fetcher_instqueue_en_in && (count_q != FULL_CNT);
`ifdef INSTQUEUE_BYPASS_EN
      // Empty queue with a ready consumer: hand the entry straight to the output stage.
      bypass = (count_q == '0) && iq.fetcher_instqueue_en_in &&
               iq.rs_instqueue_rdy_in && iq.rob_instqueue_rdy_in;
      if (bypass) begin
        push = 1'b0;
      end
`endif
      if (bypass) begin
        out_d = wr_dat;
        en_d  = 1'b1;
      end else if (pop) begin
        out_d  = rd_dat;
        en_d   = 1'b1;
        head_d = ptr_inc(head_q);
      end

      if (push) begin
        wr_en  = 1'b1;
        tail_d = ptr_inc(tail_q);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      en_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      en_q    <= en_d;
      out_q   <= out_d;
    end
  end

  // Threshold one below depth covers the fetcher's one-cycle reaction lag.
  assign iq.instqueue_fetcher_full_out    = (count_q >= THRESH_CNT);
  assign iq.instqueue_dispatcher_en_out   = en_q;
  assign iq.instqueue_dispatcher_inst_out = out_q.inst;
  assign iq.instqueue_dispatcher_pc_out   = out_q.pc;
  assign iq.instqueue_dispatcher_pred_out = out_q.pred;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a queue-based reference model checked every cycle;
// model expectations follow INSTQUEUE_BYPASS_EN when that macro is defined.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  bit   checking = 1'b0;

  inst_queue_if iq ();

  inst_queue dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .iq     (iq)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries plus the expected output stage.
  iq_entry_t mq[$];
  logic      m_en;
  iq_entry_t m_out;

  always @(posedge clk or posedge rst) begin
    automatic int        sz;
    automatic bit        take;
    automatic bit        byp;
    automatic bit        ready;
    automatic iq_entry_t in_e;
    if (rst) begin
      mq.delete();
      m_en  <= 1'b0;
      m_out <= '0;
    end else if (!rdy) begin
      m_en <= 1'b0;
    end else if (iq.rob_instqueue_rst_in) begin
      mq.delete();
      m_en <= 1'b0;
    end else begin
      sz    = mq.size();
      ready = iq.rs_instqueue_rdy_in && iq.rob_instqueue_rdy_in;
      in_e  = '{inst: iq.fetcher_instqueue_inst_in, pc: iq.fetcher_instqueue_pc_in,
                pred: iq.fetcher_instqueue_pred_in};
      take  = iq.fetcher_instqueue_en_in && (sz < QUEUE_DEPTH);
      byp   = 1'b0;
`ifdef INSTQUEUE_BYPASS_EN
      byp = (sz == 0) && iq.fetcher_instqueue_en_in && ready;
`endif
      if (byp) begin
        m_out <= in_e;
        m_en  <= 1'b1;
      end else begin
        if (sz != 0 && ready) begin
          m_out <= mq.pop_front();
          m_en  <= 1'b1;
        end else begin
          m_en <= 1'b0;
        end
        if (take) mq.push_back(in_e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && checking) begin
      check("en_out", iq.instqueue_dispatcher_en_out, m_en);
      check("full_out", iq.instqueue_fetcher_full_out, mq.size() >= QUEUE_DEPTH - 1);
      check("pc_out", iq.instqueue_dispatcher_pc_out, m_out.pc);
      check("inst_out", iq.instqueue_dispatcher_inst_out, m_out.inst);
      check("pred_out", iq.instqueue_dispatcher_pred_out, m_out.pred);
    end
  end

  logic [ADDR_W-1:0] issued[$];
  always @(negedge clk) begin
    if (!rst && iq.instqueue_dispatcher_en_out) issued.push_back(iq.instqueue_dispatcher_pc_out);
  end

  task automatic step(input bit fen, input logic [31:0] pc, input bit rs, input bit rob,
                      input bit flush);
    iq.fetcher_instqueue_en_in   = fen;
    iq.fetcher_instqueue_pc_in   = pc;
    iq.fetcher_instqueue_inst_in = pc ^ 32'h1357_9BDF;
    iq.fetcher_instqueue_pred_in = pc[2];
    iq.rs_instqueue_rdy_in       = rs;
    iq.rob_instqueue_rdy_in      = rob;
    iq.rob_instqueue_rst_in      = flush;
    @(posedge clk);
    #1;
  endtask

  initial begin
    iq.fetcher_instqueue_en_in   = 1'b0;
    iq.fetcher_instqueue_pc_in   = '0;
    iq.fetcher_instqueue_inst_in = '0;
    iq.fetcher_instqueue_pred_in = 1'b0;
    iq.rs_instqueue_rdy_in       = 1'b0;
    iq.rob_instqueue_rdy_in      = 1'b0;
    iq.rob_instqueue_rst_in      = 1'b0;

    #2;
    check("rst_en", iq.instqueue_dispatcher_en_out, 0);
    check("rst_pc", iq.instqueue_dispatcher_pc_out, 0);
    check("rst_inst", iq.instqueue_dispatcher_inst_out, 0);
    check("rst_pred", iq.instqueue_dispatcher_pred_out, 0);
    check("rst_full", iq.instqueue_fetcher_full_out, 0);
    #6;
    rst = 1'b0;
    checking = 1'b1;
    @(posedge clk);
    #1;

    // Fill: full at 15, 16th accepted, 17th dropped.
    for (int i = 0; i < 14; i++) step(1, 32'(i * 4), 0, 0, 0);
    check("fill14_full", iq.instqueue_fetcher_full_out, 0);
    step(1, 32'h38, 0, 0, 0);
    check("fill15_full", iq.instqueue_fetcher_full_out, 1);
    step(1, 32'h3C, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0);
    check("fill17_full", iq.instqueue_fetcher_full_out, 1);
    issued.delete();
    for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    check("drain_count", issued.size(), 16);
    for (int i = 0; i < 16 && i < issued.size(); i++) check("drain_pc", issued[i], 64'(i * 4));
    check("drain_full", iq.instqueue_fetcher_full_out, 0);

    // Push into an empty queue with a ready consumer.
    step(1, 32'h80, 1, 1, 0);
`ifdef INSTQUEUE_BYPASS_EN
    check("byp_en", iq.instqueue_dispatcher_en_out, 1);
    check("byp_pc", iq.instqueue_dispatcher_pc_out, 32'h80);
    step(0, 0, 1, 1, 0);
    check("byp_after_en", iq.instqueue_dispatcher_en_out, 0);
`else
    check("nobyp_en", iq.instqueue_dispatcher_en_out, 0);
    step(0, 0, 1, 1, 0);
    check("nobyp_en2", iq.instqueue_dispatcher_en_out, 1);
    check("nobyp_pc", iq.instqueue_dispatcher_pc_out, 32'h80);
`endif
    step(0, 0, 0, 0, 0);

    // Wrap: 20 push/pop pairs with one entry resident.
    issued.delete();
    step(1, 32'h100, 0, 0, 0);
    for (int i = 1; i <= 20; i++) step(1, 32'h100 + 32'(4 * i), 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    check("wrap_count", issued.size(), 21);
    for (int i = 0; i < 21 && i < issued.size(); i++)
      check("wrap_pc", issued[i], 64'(32'h100 + 32'(4 * i)));

    // ROB backpressure with three entries queued.
    for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(4 * i), 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      check("bp_hold_en", iq.instqueue_dispatcher_en_out, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0);
      check("bp_rel_en", iq.instqueue_dispatcher_en_out, 1);
      check("bp_rel_pc", iq.instqueue_dispatcher_pc_out, 32'h200 + 32'(4 * i));
    end
    step(0, 0, 1, 1, 0);
    check("bp_done_en", iq.instqueue_dispatcher_en_out, 0);

    // Flush with a simultaneous push at count 7.
    for (int i = 0; i < 7; i++) step(1, 32'h300 + 32'(4 * i), 0, 0, 0);
    step(1, 32'hDEAD0, 0, 0, 1);
    check("flush_en", iq.instqueue_dispatcher_en_out, 0);
    check("flush_full", iq.instqueue_fetcher_full_out, 0);
    step(0, 0, 1, 1, 0);
    check("flush_empty_en", iq.instqueue_dispatcher_en_out, 0);
    step(1, 32'h500, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    check("flush_next_en", iq.instqueue_dispatcher_en_out, 1);
    check("flush_next_pc", iq.instqueue_dispatcher_pc_out, 32'h500);
    step(0, 0, 0, 0, 0);

    // Global ready low freezes the queue mid-drain.
    for (int i = 0; i < 3; i++) step(1, 32'h600 + 32'(4 * i), 0, 0, 0);
    step(0, 0, 1, 1, 0);
    check("rdy_first_pc", iq.instqueue_dispatcher_pc_out, 32'h600);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1, 32'h6F0, 1, 1, 0);
      check("rdy_low_en", iq.instqueue_dispatcher_en_out, 0);
      check("rdy_low_pc", iq.instqueue_dispatcher_pc_out, 32'h600);
    end
    rdy = 1'b1;
    step(0, 0, 1, 1, 0);
    check("rdy_resume_pc1", iq.instqueue_dispatcher_pc_out, 32'h604);
    step(0, 0, 1, 1, 0);
    check("rdy_resume_pc2", iq.instqueue_dispatcher_pc_out, 32'h608);
    step(0, 0, 1, 1, 0);
    check("rdy_resume_end", iq.instqueue_dispatcher_en_out, 0);

    // Asynchronous reset with count 5 and en_out high.
    for (int i = 0; i < 6; i++) step(1, 32'h700 + 32'(4 * i), 0, 0, 0);
    step(0, 0, 1, 1, 0);
    check("pre_rst_en", iq.instqueue_dispatcher_en_out, 1);
    rst = 1'b1;
    #1;
    check("async_rst_en", iq.instqueue_dispatcher_en_out, 0);
    check("async_rst_pc", iq.instqueue_dispatcher_pc_out, 0);
    check("async_rst_full", iq.instqueue_fetcher_full_out, 0);
    #2;
    rst = 1'b0;
    step(1, 32'h800, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    check("post_rst_en", iq.instqueue_dispatcher_en_out, 1);
    check("post_rst_pc", iq.instqueue_dispatcher_pc_out, 32'h800);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
